// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: default widths, opcode
// constants, FSM state encoding and the command word layout.
package alu_pkg;

    localparam int ALU_W   = 4;
    localparam int ALU_OPW = 4;

    localparam logic [ALU_OPW-1:0] ALU_OP_ADD = 4'h0;
    localparam logic [ALU_OPW-1:0] ALU_OP_SUB = 4'h1;
    localparam logic [ALU_OPW-1:0] ALU_OP_MUL = 4'h2;
    localparam logic [ALU_OPW-1:0] ALU_OP_DIV = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    // Command word as stored in the FIFO, MSB first: {use_acc, op, a, b}.
    typedef struct packed {
        logic               use_acc;
        logic [ALU_OPW-1:0] op;
        logic [ALU_W-1:0]   a;
        logic [ALU_W-1:0]   b;
    } alu_cmd_t;

    localparam int ALU_CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Small synchronous FIFO holding pending ALU commands. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module alu_cmd_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset simply empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time on registered operands,
// captures the combinational ALU result and hands it downstream. The last
// result is kept in an accumulator that a command may use in place of A.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight; pop the FIFO head as soon as one exists
// ST_ISSUE | operands on the ALU for one full cycle; capture at the edge
// ST_RESP  | result valid, held until res_ready; may chain the next pop
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int OPW   = ALU_OPW,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic           cmd_use_acc,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_res,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_data,
    output logic [OPW-1:0] res_op,
    output logic           busy
);

    localparam int CW = 1 + OPW + 2 * W;

    seq_state_t     state_q, state_d;
    logic [CW-1:0]  fifo_din;
    logic [CW-1:0]  fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           load;
    logic           capture;
    logic           res_clr;

    logic           head_use_acc;
    logic [OPW-1:0] head_op;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    logic [OPW-1:0] alu_op_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic           res_valid_q;
    logic [W-1:0]   res_data_q;
    logic [OPW-1:0] res_op_q;
    logic [W-1:0]   acc_q;

    // Acceptance looks at full only, so a pop in the same cycle never frees a slot early.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign fifo_din  = {cmd_use_acc, cmd_op, cmd_a, cmd_b};

    assign head_use_acc = fifo_dout[CW-1];
    assign head_op      = fifo_dout[2*W +: OPW];
    assign head_a       = fifo_dout[W +: W];
    assign head_b       = fifo_dout[0 +: W];

    alu_cmd_fifo #(
        .DW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath strobes; a pop always loads the ALU operands.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        res_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_clr = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand, result and accumulator registers; operands hold when not loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            acc_q       <= '0;
        end else begin
            if (load) begin
                alu_op_q <= head_op;
                alu_a_q  <= head_use_acc ? acc_q : head_a;
                alu_b_q  <= head_b;
            end
            if (capture) begin
                res_data_q  <= alu_res;
                res_op_q    <= alu_op_q;
                acc_q       <= alu_res;
                res_valid_q <= 1'b1;
            end else if (res_clr) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed plus randomized bench for alu_cmd_sequencer. The ALU is a
// behavioural function; the reference model treats the block as an ordered
// command queue with an accumulator, checked at each result handshake.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_acc;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [3:0] res_op;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nres   = 0;

    logic [12:0] q[$];
    logic [3:0]  acc_m = 4'h0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: begin p = a * b; return p[3:0]; end
            4'h3: return (b == 4'h0) ? 4'hF : a / b;
            4'h4: return a & b;
            4'h5: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);

    alu_cmd_sequencer #(.W(4), .OPW(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_res     (alu_res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_op      (res_op),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note the handshakes set up before the edge, then update the model.
    task automatic tick();
        logic        dp, dr, r;
        logic [12:0] c, h;
        logic [3:0]  rd, ro, a_eff, exp;
        r  = rst;
        dp = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        dr = (res_valid === 1'b1) && (res_ready === 1'b1);
        c  = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
        rd = res_data;
        ro = res_op;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            q.delete();
            acc_m = 4'h0;
        end else begin
            if (dr) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    h     = q.pop_front();
                    a_eff = h[12] ? acc_m : h[7:4];
                    exp   = alu_f(h[11:8], a_eff, h[3:0]);
                    chk("res_data", {28'd0, rd}, {28'd0, exp});
                    chk("res_op", {28'd0, ro}, {28'd0, h[11:8]});
                    acc_m = exp;
                    nres++;
                end
            end
            if (dp) q.push_back(c);
        end
    endtask

    task automatic set_cmd(input logic v, input logic ua, input logic [3:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        cmd_valid   = v;
        cmd_use_acc = ua;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
    endtask

    initial begin
        int          last_cyc;
        int          prev_n;
        int          start_n;
        logic [3:0]  held;

        // Reset with cmd_valid asserted: nothing may be accepted.
        rst       = 1'b1;
        res_ready = 1'b0;
        set_cmd(1'b1, 1'b0, 4'h0, 4'h5, 4'h6);
        tick();
        tick();
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_res_data", {28'd0, res_data}, 32'd0);
        chk("rst_res_op", {28'd0, res_op}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rst_no_push", {31'd0, busy}, 32'd0);

        // Single op: ADD(1,1), latency pop at N+1, result at N+2.
        set_cmd(1'b1, 1'b0, 4'h0, 4'h1, 4'h1);
        tick();
        cmd_valid = 1'b0;
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_rv_n", {31'd0, res_valid}, 32'd0);
        tick();
        chk("single_alu_a", {28'd0, alu_a}, 32'd1);
        chk("single_alu_b", {28'd0, alu_b}, 32'd1);
        chk("single_rv_n1", {31'd0, res_valid}, 32'd0);
        tick();
        chk("single_rv_n2", {31'd0, res_valid}, 32'd1);
        chk("single_data", {28'd0, res_data}, 32'd2);
        chk("single_op", {28'd0, res_op}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_rv_done", {31'd0, res_valid}, 32'd0);
        chk("single_busy_done", {31'd0, busy}, 32'd0);
        chk("single_hold_a", {28'd0, alu_a}, 32'd1);

        // Chain: ADD(3,2) then SUB(acc,1).
        start_n = nres;
        res_ready = 1'b1;
        set_cmd(1'b1, 1'b0, 4'h0, 4'h3, 4'h2);
        tick();
        set_cmd(1'b1, 1'b1, 4'h1, 4'h9, 4'h1);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("chain_alu_a", {28'd0, alu_a}, 32'd5);
        chk("chain_alu_op", {28'd0, alu_op}, 32'd1);
        tick();
        tick();
        chk("chain_nres", nres - start_n, 32'd2);
        chk("chain_busy", {31'd0, busy}, 32'd0);

        // Backpressure: six pushes offered, five accepted, FIFO full.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_cmd(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    4'($urandom), 4'($urandom));
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_accepted", q.size(), 32'd5);
        chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
        held = res_data;
        tick();
        tick();
        tick();
        chk("bp_res_stable", {28'd0, res_data}, {28'd0, held});
        chk("bp_still_valid", {31'd0, res_valid}, 32'd1);

        // Drain: five results, one every two cycles, then idle.
        res_ready = 1'b1;
        start_n   = nres;
        last_cyc  = -1;
        for (int i = 0; i < 40 && (busy === 1'b1 || res_valid === 1'b1); i++) begin
            prev_n = nres;
            tick();
            if (nres != prev_n) begin
                if (last_cyc >= 0) chk("drain_gap", cyc - last_cyc, 32'd2);
                last_cyc = cyc;
            end
        end
        chk("drain_nres", nres - start_n, 32'd5);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_q_empty", q.size(), 32'd0);

        // Reset mid-RESP with three commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b0, 4'h2, 4'($urandom), 4'($urandom));
            tick();
        end
        cmd_valid = 1'b0;
        chk("mid_res_valid", {31'd0, res_valid}, 32'd1);
        chk("mid_pending", q.size(), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rv", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        set_cmd(1'b1, 1'b1, 4'h0, 4'h7, 4'h3);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_acc_zero", {28'd0, alu_a}, 32'd0);
        chk("mid_alu_b", {28'd0, alu_b}, 32'd3);
        tick();
        res_ready = 1'b1;
        start_n = nres;
        tick();
        chk("mid_nres", nres - start_n, 32'd1);

        // Randomized traffic against the queue/accumulator model.
        for (int i = 0; i < 400; i++) begin
            set_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 60 && (busy === 1'b1 || res_valid === 1'b1); i++) tick();
        chk("rand_q_empty", q.size(), 32'd0);
        chk("rand_busy", {31'd0, busy}, 32'd0);
        chk("rand_res_valid", {31'd0, res_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
